// File: rtl/score_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : score_bcd_counter
//  Summary  : Dinosaur-runner game score. Counts play time as four packed
//             BCD digits, paced by rising edges of the slow movement clock
//             (step_clk, sampled as asynchronous data). Saturates at 9999.
//             Optional best-of-session high score, enabled by defining the
//             macro SCORE_HISCORE_EN (default build: disabled, hiscore = 0,
//             disp = score).
//  Revision : 1.0  initial release
// ============================================================================
module score_bcd_counter #(
    parameter int STEPS_PER_POINT = 8
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        step_clk,
    input  logic        run,
    input  logic        clear,
    input  logic        show_hi,
    output logic [15:0] score,
    output logic        sat,
    output logic [15:0] disp,
    output logic [15:0] hiscore
);

    localparam logic [7:0]  c_pre_last = 8'(STEPS_PER_POINT - 1);
    localparam logic [15:0] c_score_max = 16'h9999;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_edge_q;
    logic        r_step;
    logic [7:0]  r_pre;
    logic [15:0] r_score;
    logic        r_sat;
    logic [15:0] w_score_inc;

    // Two-flop synchronizer for step_clk, then rising-edge detect into a
    // registered one-cycle step pulse.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_edge_q <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            r_sync1  <= step_clk;
            r_sync2  <= r_sync1;
            r_edge_q <= r_sync2;
            r_step   <= r_sync2 & ~r_edge_q;
        end
    end

    // BCD ripple increment of the current score: a digit at 9 wraps to 0 and
    // carries into the next digit up.
    always_comb begin
        logic carry;
        carry       = 1'b1;
        w_score_inc = r_score;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
    end

    // Prescaler and score register; clear wins over a coincident step, and a
    // point due at 9999 sets the sticky saturation flag instead of wrapping.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_pre   <= 8'd0;
            r_score <= 16'h0000;
            r_sat   <= 1'b0;
        end else if (clear) begin
            r_pre   <= 8'd0;
            r_score <= 16'h0000;
            r_sat   <= 1'b0;
        end else if (r_step && run) begin
            if (r_pre == c_pre_last) begin
                r_pre <= 8'd0;
                if (r_score == c_score_max) begin
                    r_sat <= 1'b1;
                end else begin
                    r_score <= w_score_inc;
                end
            end else begin
                r_pre <= r_pre + 8'd1;
            end
        end
    end

    assign score = r_score;
    assign sat   = r_sat;

`ifdef SCORE_HISCORE_EN
    logic [15:0] r_hiscore;

    // Best score since Reset; packed BCD orders correctly as unsigned binary.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_hiscore <= 16'h0000;
        end else if (r_score > r_hiscore) begin
            r_hiscore <= r_score;
        end
    end

    assign hiscore = r_hiscore;
    assign disp    = show_hi ? r_hiscore : r_score;
`else
    logic w_unused_show_hi;

    assign w_unused_show_hi = show_hi;
    assign hiscore          = 16'h0000;
    assign disp             = r_score;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_bcd_counter
//  Summary  : Self-checking bench for score_bcd_counter. Instance A uses
//             STEPS_PER_POINT=8, instance B uses 1 for the long run to 9999.
//  Revision : 1.0  initial release
// ============================================================================
module tb_score_bcd_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_step = 1'b0, a_run = 1'b0, a_clear = 1'b0, a_show = 1'b0;
    logic [15:0] a_score, a_disp, a_hiscore;
    logic        a_sat;

    logic        b_step = 1'b0, b_run = 1'b0, b_clear = 1'b0, b_show = 1'b0;
    logic [15:0] b_score, b_disp, b_hiscore;
    logic        b_sat;

    int checks   = 0;
    int failures = 0;
    int bad_bcd  = 0;

    // reference model state for instance A: plain integer score
    int   m_pts, m_pre, m_hi;
    logic m_sat;

    typedef struct {
        logic        clr;
        logic        run;
        int          edges;
        logic [15:0] exp_score;
        logic        exp_sat;
    } vec_t;
    vec_t tbl[11];

    score_bcd_counter #(.STEPS_PER_POINT(8)) dut_a (
        .ClkPort(clk), .Reset(rst), .step_clk(a_step), .run(a_run),
        .clear(a_clear), .show_hi(a_show), .score(a_score), .sat(a_sat),
        .disp(a_disp), .hiscore(a_hiscore)
    );

    score_bcd_counter #(.STEPS_PER_POINT(1)) dut_b (
        .ClkPort(clk), .Reset(rst), .step_clk(b_step), .run(b_run),
        .clear(b_clear), .show_hi(b_show), .score(b_score), .sat(b_sat),
        .disp(b_disp), .hiscore(b_hiscore)
    );

    always #5 clk = ~clk;

    // every digit of both score buses must always be a legal BCD value
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (a_score[4*d +: 4] > 4'd9 || b_score[4*d +: 4] > 4'd9) bad_bcd++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit expired, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_hi();
`ifdef SCORE_HISCORE_EN
        return to_bcd(m_hi);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] exp_disp();
`ifdef SCORE_HISCORE_EN
        return a_show ? to_bcd(m_hi) : to_bcd(m_pts);
`else
        return to_bcd(m_pts);
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pts = 0; m_pre = 0; m_sat = 1'b0;
    endtask

    task automatic model_step();
        m_pre++;
        if (m_pre == 8) begin
            m_pre = 0;
            if (m_pts == 9999) m_sat = 1'b1;
            else m_pts++;
        end
    endtask

    // one step_clk rising edge on A (entered and left on a falling clk edge);
    // optionally strobes clear in the very cycle the step pulse is seen
    task automatic a_edge(input logic do_clr);
        logic [15:0] hi_before;
        hi_before = exp_hi();
        a_step = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); a_step = 1'b0;
        @(posedge clk);
        @(negedge clk); if (do_clr) a_clear = 1'b1;
        @(posedge clk);
        @(negedge clk); a_clear = 1'b0;
        if (do_clr) model_clear();
        else if (a_run) model_step();
        chk("score", a_score, to_bcd(m_pts));
        chk("sat", {15'd0, a_sat}, {15'd0, m_sat});
        chk("hiscore_lag", a_hiscore, hi_before);
        @(posedge clk); @(negedge clk);
        if (m_pts > m_hi) m_hi = m_pts;
        chk("hiscore", a_hiscore, exp_hi());
        chk("disp", a_disp, exp_disp());
    endtask

    task automatic a_points(input int n);
        a_run = 1'b1;
        repeat (n * 8) a_edge(1'b0);
    endtask

    task automatic a_do_clear();
        a_clear = 1'b1;
        @(posedge clk);
        @(negedge clk); a_clear = 1'b0;
        model_clear();
        chk("clear_score", a_score, 16'h0000);
        chk("clear_sat", {15'd0, a_sat}, 16'h0000);
        @(posedge clk); @(negedge clk);
        chk("clear_keeps_hi", a_hiscore, exp_hi());
    endtask

    task automatic b_edge();
        b_step = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); b_step = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_step = 0; a_run = 0; a_clear = 0; a_show = 0;
        b_step = 0; b_run = 0; b_clear = 0; b_show = 0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_hi = 0;
        chk("rst_score", a_score, 16'h0000);
        chk("rst_sat", {15'd0, a_sat}, 16'h0000);
        chk("rst_disp", a_disp, 16'h0000);
        chk("rst_hiscore", a_hiscore, 16'h0000);
        chk("rst_b_score", b_score, 16'h0000);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1,  7, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1,  1, 16'h0001, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 72, 16'h0010, 1'b0};
        tbl[3]  = '{1'b0, 1'b1,  5, 16'h0010, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 20, 16'h0010, 1'b0};
        tbl[5]  = '{1'b0, 1'b1,  2, 16'h0010, 1'b0};
        tbl[6]  = '{1'b0, 1'b1,  1, 16'h0011, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 11, 16'h0001, 1'b0};
        tbl[8]  = '{1'b1, 1'b1,  3, 16'h0000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1,  4, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 1'b1,  1, 16'h0001, 1'b0};

        // first point: latency from the 8th step_clk edge
        do_reset();
        a_run = 1'b1;
        repeat (7) a_edge(1'b0);
        a_step = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); a_step = 1'b0;
        @(posedge clk); #1;
        chk("latency_3cyc", a_score, 16'h0000);
        @(posedge clk); #1;
        chk("latency_4cyc", a_score, 16'h0001);
        @(negedge clk);
        m_pts = 1; m_pre = 0;
        @(posedge clk); @(negedge clk);
        m_hi = 1;

        // table of run/clear/edge-count vectors with expected score
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].clr) a_do_clear();
            a_run = tbl[i].run;
            repeat (tbl[i].edges) a_edge(1'b0);
            chk($sformatf("tbl%0d_score", i), a_score, tbl[i].exp_score);
            chk($sformatf("tbl%0d_sat", i), {15'd0, a_sat}, {15'd0, tbl[i].exp_sat});
        end

        // clear coincident with a step pulse: step dropped
        a_run = 1'b1;
        repeat (3) a_edge(1'b0);
        a_edge(1'b1);
        chk("clr_vs_step", a_score, 16'h0000);
        repeat (7) a_edge(1'b0);
        chk("clr_vs_step_pre", a_score, 16'h0000);
        a_edge(1'b0);
        chk("clr_vs_step_pt", a_score, 16'h0001);

        // randomized run / clear / show_hi against the model
        for (int i = 0; i < 150; i++) begin
            a_run  = ($urandom_range(0, 3) != 0);
            a_show = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) a_do_clear();
            a_edge($urandom_range(0, 24) == 0);
        end

        // high score kept across a clear, then overtaken
        do_reset();
        a_points(42);
        a_do_clear();
        a_points(17);
        a_show = 1'b1;
        @(negedge clk);
`ifdef SCORE_HISCORE_EN
        chk("hs_hold", a_hiscore, 16'h0042);
        chk("hs_disp", a_disp, 16'h0042);
`else
        chk("hs_off", a_hiscore, 16'h0000);
        chk("hs_off_disp", a_disp, 16'h0017);
`endif
        a_points(26);
        chk("hs_score43", a_score, 16'h0043);
`ifdef SCORE_HISCORE_EN
        chk("hs_43", a_hiscore, 16'h0043);
`else
        chk("hs_off_43", a_hiscore, 16'h0000);
`endif
        a_show = 1'b0;

        // asynchronous reset mid-count
        do_reset();
        a_points(123);
        a_run = 1'b1;
        repeat (3) a_edge(1'b0);
        chk("pre_rst_score", a_score, 16'h0123);
        #2 rst = 1'b1;
        #1;
        chk("arst_score", a_score, 16'h0000);
        chk("arst_sat", {15'd0, a_sat}, 16'h0000);
        chk("arst_disp", a_disp, 16'h0000);
        chk("arst_hiscore", a_hiscore, 16'h0000);
        @(negedge clk); rst = 1'b0;
        model_clear();
        m_hi = 0;
        // partial prescale discarded: 8 more edges give exactly one point
        repeat (7) a_edge(1'b0);
        chk("arst_pre7", a_score, 16'h0000);
        a_edge(1'b0);
        chk("arst_pre8", a_score, 16'h0001);

        // instance B: one point per edge, through 0999->1000 and up to 9999
        do_reset();
        b_run = 1'b1;
        for (int i = 1; i <= 10015; i++) begin
            b_edge();
            if (i == 999)   chk("b_0999", b_score, 16'h0999);
            if (i == 1000)  chk("b_1000", b_score, 16'h1000);
            if (i == 9998)  chk("b_sat_early", {15'd0, b_sat}, 16'h0000);
            if (i == 9999) begin
                chk("b_9999", b_score, 16'h9999);
                chk("b_sat_at_9999", {15'd0, b_sat}, 16'h0000);
            end
        end
        chk("b_hold", b_score, 16'h9999);
        chk("b_sat", {15'd0, b_sat}, 16'h0001);
        chk("b_disp", b_disp, 16'h9999);
        b_clear = 1'b1;
        @(posedge clk); #1;
        chk("b_clr_score", b_score, 16'h0000);
        chk("b_clr_sat", {15'd0, b_sat}, 16'h0000);
        @(negedge clk); b_clear = 1'b0;

        chk("bcd_digits", {15'd0, bad_bcd == 0}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
